iq_issue_arbiter: RTL and testbench
===================================

// Module: iq_issue_arbiter
// PURPOSE
//  Shares one non-pipelined / partially pipelined functional unit between NUM_REQ issue queues.
//  Each cycle it picks at most one ready queue (round-robin) and pulses that queue's issue input.
//  It registers the granted op (func, src tags, dst tag) into the FU input register and blocks new
//  grants until the FU occupancy interval expires. Sits between the issue queues and the FU.
// PARAMETERS
//  NUM_REQ   4  number of issue queues sharing the FU (>=2)
//  FUNC_W    4  width of the op function code (ALU1_FUNC encoding)
//  TAG_W     5  physical register tag width (matches REG_ADDR_LEN)
//  LATENCY   2  FU occupancy in cycles per op; 1 = fully pipelined (>=1)
// PORTS
//  clk        in   1                clock; all state updates on posedge
//  reset      in   1                synchronous, active-high reset
//  req_valid  in   NUM_REQ          queue i has a ready entry (queue's issue_ready)
//  req_func   in   NUM_REQ*FUNC_W   head-ready op of queue i, slice [i*FUNC_W +: FUNC_W]
//  req_src1   in   NUM_REQ*TAG_W    src1 tag of queue i, slice [i*TAG_W +: TAG_W]
//  req_src2   in   NUM_REQ*TAG_W    src2 tag of queue i
//  req_dst    in   NUM_REQ*TAG_W    dst tag of queue i
//  fu_stall   in   1                FU cannot accept the presented op this cycle
//  grant      out  NUM_REQ          one-hot issue pulse to queue i (combinational)
//  fu_valid   out  1                FU input register holds a valid op
//  fu_func    out  FUNC_W           registered op to FU
//  fu_src1    out  TAG_W            registered src1 tag
//  fu_src2    out  TAG_W            registered src2 tag
//  fu_dst     out  TAG_W            registered dst tag
//  fu_owner   out  $clog2(NUM_REQ)  index of queue that owns the op in the FU register
//  fu_busy    out  1                occupancy counter nonzero or op stalled (no grant possible)
// BEHAVIOUR
//  Reset: fu_valid=0, fu_func/src1/src2/dst/owner=0, busy_cnt=0, rr_ptr=0; grant forced 0 while reset=1.
//  Reset mid-operation discards the in-flight op; no grant in the reset cycle; normal next cycle.
//  States: IDLE (busy_cnt==0, no stalled op), BUSY (busy_cnt>0), STALL (fu_valid & fu_stall).
//  can_grant = !reset & (busy_cnt==0) & !(fu_valid & fu_stall).
//  Arbitration: search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
//   grant[w]=1 only if can_grant and any req_valid; at most one bit set; never two in one cycle.
//  On grant edge: fu_* <= slices of winner w, fu_owner<=w, fu_valid<=1, rr_ptr<=(w+1)%NUM_REQ,
//   busy_cnt<=LATENCY-1 (state -> BUSY if LATENCY>1, else stays IDLE).
//  Latency: grant in cycle t -> op on fu_* with fu_valid=1 in cycle t+1.
//  No grant and no stall: fu_valid<=0; busy_cnt decrements by 1 if >0 (saturates at 0).
//  STALL: fu_valid & fu_stall holds fu_* , fu_owner, fu_valid, busy_cnt and rr_ptr unchanged; grant=0.
//   Leaving STALL (fu_stall=0) behaves as a normal cycle: op accepted, grant allowed if busy_cnt==0.
//  Next grant after a grant at t: earliest cycle t+LATENCY, delayed by every stall cycle.
//  fu_stall while fu_valid=0 is ignored.
//  fu_busy = (busy_cnt!=0) | (fu_valid & fu_stall).
//  req_valid with no grant: no state change; requests are level, queue keeps the entry.
//  rr_ptr wraps NUM_REQ-1 -> 0; unchanged on cycles without a grant.
// TESTING
//  T1 reset=1 2 cycles, req_valid=4'b1111 -> grant=0, fu_valid=0, fu_busy=0, all fu_* 0.
//  T2 LATENCY=2, req_valid=4'b0100 held, req_func[2]=ALU_ADD, dst=5'b00011 -> grant=4'b0100
//     at cycles 0,2,4 only; fu_valid=1 at 1,3,5 with fu_func=ALU_ADD, fu_dst=3, fu_owner=2.
//  T3 LATENCY=1, req_valid=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001 on
//     consecutive cycles; fu_owner follows 0,1,2,3,0 one cycle later.
//  T4 LATENCY=1, grant to q0 (rr_ptr->1), then req_valid=4'b1001 -> grant q3, then q0.
//  T5 op from q1 in FU, fu_stall=1 for 3 cycles, req_valid=4'b1111 -> grant=0, fu_* and
//     fu_owner=1 held, fu_busy=1; after release grant resumes at q2.
//  T6 reset asserted in BUSY (busy_cnt=1, fu_valid=1) -> next cycle fu_valid=0, fu_busy=0,
//     rr_ptr=0; first grant after reset goes to lowest-index valid queue.

Source files
------------

// File: rtl/iq_issue_arbiter.sv
// Round-robin issue arbiter that shares one functional unit between NUM_REQ issue queues.
// Registers the winning op into the FU input register and blocks new grants while the FU is occupied.
module iq_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FUNC_W  = 4,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FUNC_W-1:0]    req_func,
  input  logic [NUM_REQ*TAG_W-1:0]     req_src1,
  input  logic [NUM_REQ*TAG_W-1:0]     req_src2,
  input  logic [NUM_REQ*TAG_W-1:0]     req_dst,
  input  logic                         fu_stall,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         fu_valid,
  output logic [FUNC_W-1:0]            fu_func,
  output logic [TAG_W-1:0]             fu_src1,
  output logic [TAG_W-1:0]             fu_src2,
  output logic [TAG_W-1:0]             fu_dst,
  output logic [$clog2(NUM_REQ)-1:0]   fu_owner,
  output logic                         fu_busy
);

  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, STALL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   busy_cnt;
  logic [OWNER_W-1:0] rr_ptr;
  logic [OWNER_W-1:0] win;
  logic               found;
  logic               do_grant;

  // A stalled op takes priority over the occupancy count: both block grants.
  always_comb begin
    state = IDLE;
    if (fu_valid && fu_stall)
      state = STALL;
    else if (busy_cnt != '0)
      state = BUSY;
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = OWNER_W'(idx);
      end
    end
  end

  assign do_grant = !reset && (state == IDLE) && found;
  assign fu_busy  = (state != IDLE);

  always_comb begin
    grant = '0;
    if (do_grant)
      grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fu_valid <= 1'b0;
      fu_func  <= '0;
      fu_src1  <= '0;
      fu_src2  <= '0;
      fu_dst   <= '0;
      fu_owner <= '0;
      busy_cnt <= '0;
      rr_ptr   <= '0;
    end else if (state == STALL) begin
      fu_valid <= fu_valid;
    end else if (do_grant) begin
      fu_valid <= 1'b1;
      fu_func  <= req_func[win*FUNC_W +: FUNC_W];
      fu_src1  <= req_src1[win*TAG_W +: TAG_W];
      fu_src2  <= req_src2[win*TAG_W +: TAG_W];
      fu_dst   <= req_dst[win*TAG_W +: TAG_W];
      fu_owner <= win;
      busy_cnt <= CNT_W'(LATENCY - 1);
      rr_ptr   <= OWNER_W'((int'(win) + 1) % NUM_REQ);
    end else begin
      fu_valid <= 1'b0;
      if (busy_cnt != '0)
        busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iq_issue_arbiter.sv
// Bench for iq_issue_arbiter: one instance with LATENCY=2 and one with LATENCY=1 share stimulus;
// directed vector table followed by randomized cycles, both checked against a cycle-count reference model.
module tb_iq_issue_arbiter;

  localparam int N  = 4;
  localparam int FW = 4;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*FW-1:0] req_func;
  logic [N*TW-1:0] req_src1;
  logic [N*TW-1:0] req_src2;
  logic [N*TW-1:0] req_dst;
  logic            fu_stall;

  logic [N-1:0]  grant2, grant1;
  logic          fu_valid2, fu_valid1, fu_busy2, fu_busy1;
  logic [FW-1:0] fu_func2, fu_func1;
  logic [TW-1:0] fu_src1_2, fu_src1_1, fu_src2_2, fu_src2_1, fu_dst2, fu_dst1;
  logic [1:0]    fu_owner2, fu_owner1;

  iq_issue_arbiter #(.NUM_REQ(N), .FUNC_W(FW), .TAG_W(TW), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_func(req_func),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .fu_stall(fu_stall),
    .grant(grant2), .fu_valid(fu_valid2), .fu_func(fu_func2), .fu_src1(fu_src1_2),
    .fu_src2(fu_src2_2), .fu_dst(fu_dst2), .fu_owner(fu_owner2), .fu_busy(fu_busy2)
  );

  iq_issue_arbiter #(.NUM_REQ(N), .FUNC_W(FW), .TAG_W(TW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_func(req_func),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .fu_stall(fu_stall),
    .grant(grant1), .fu_valid(fu_valid1), .fu_func(fu_func1), .fu_src1(fu_src1_1),
    .fu_src2(fu_src2_1), .fu_dst(fu_dst1), .fu_owner(fu_owner1), .fu_busy(fu_busy1)
  );

  always #5 clk = ~clk;

  // Reference model: "since" counts non-stalled cycles since the last grant, so a grant is
  // allowed once it reaches the latency.
  typedef struct {
    bit valid;
    int owner;
    int func;
    int src1;
    int src2;
    int dst;
    int since;
    int ptr;
    bit fresh;
  } model_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       stall;
    logic [3:0] g2;
    logic [3:0] g1;
  } vec_t;

  model_t m2, m1;
  vec_t   vecs[26];
  int     checks = 0;
  int     errors = 0;

  function automatic model_t model_reset(input int lat);
    model_t m;
    m.valid = 0; m.owner = 0; m.func = 0; m.src1 = 0; m.src2 = 0; m.dst = 0;
    m.since = lat; m.ptr = 0; m.fresh = 1;
    return m;
  endfunction

  function automatic int pick(input model_t m, input int lat, input logic r,
                              input logic st, input logic [N-1:0] req);
    if (r || (m.valid && st) || m.since < lat)
      return -1;
    for (int k = 0; k < N; k++)
      if (req[(m.ptr + k) % N])
        return (m.ptr + k) % N;
    return -1;
  endfunction

  function automatic model_t advance(input model_t m, input int lat, input logic r,
                                     input logic st, input int w);
    model_t n;
    n = m;
    if (r) begin
      n = model_reset(lat);
    end else if (m.valid && st) begin
      n = m;
    end else if (w >= 0) begin
      n.valid = 1;
      n.owner = w;
      n.func  = int'(req_func[w*FW +: FW]);
      n.src1  = int'(req_src1[w*TW +: TW]);
      n.src2  = int'(req_src2[w*TW +: TW]);
      n.dst   = int'(req_dst[w*TW +: TW]);
      n.since = 1;
      n.ptr   = (w + 1) % N;
      n.fresh = 0;
    end else begin
      n.valid = 0;
      if (n.since < lat)
        n.since = n.since + 1;
    end
    return n;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input model_t m, input int lat, input int w,
                              input logic [N-1:0] g, input logic fv, input logic fb,
                              input logic [FW-1:0] ff, input logic [TW-1:0] f1,
                              input logic [TW-1:0] f2, input logic [TW-1:0] fd,
                              input logic [1:0] fo);
    logic [N-1:0] eg;
    eg = '0;
    if (w >= 0)
      eg[w] = 1'b1;
    check_val({tag, "_grant"}, 32'(g), 32'(eg));
    check_val({tag, "_fu_valid"}, 32'(fv), 32'(m.valid));
    check_val({tag, "_fu_busy"}, 32'(fb), 32'((m.since < lat) || (m.valid && fu_stall)));
    if (m.valid || m.fresh) begin
      check_val({tag, "_fu_func"}, 32'(ff), 32'(m.func));
      check_val({tag, "_fu_src1"}, 32'(f1), 32'(m.src1));
      check_val({tag, "_fu_src2"}, 32'(f2), 32'(m.src2));
      check_val({tag, "_fu_dst"}, 32'(fd), 32'(m.dst));
      check_val({tag, "_fu_owner"}, 32'(fo), 32'(m.owner));
    end
  endtask

  // Inputs are driven just after a posedge, checked at the negedge, model advanced at the next posedge.
  task automatic apply_stimulus(input logic r, input logic [N-1:0] req, input logic st,
                                input bit use_table, input logic [3:0] tg2, input logic [3:0] tg1);
    int w2, w1;
    model_t n2, n1;
    reset     = r;
    req_valid = req;
    fu_stall  = st;
    @(negedge clk);
    w2 = pick(m2, 2, r, st, req);
    w1 = pick(m1, 1, r, st, req);
    check_output("lat2", m2, 2, w2, grant2, fu_valid2, fu_busy2, fu_func2, fu_src1_2,
                 fu_src2_2, fu_dst2, fu_owner2);
    check_output("lat1", m1, 1, w1, grant1, fu_valid1, fu_busy1, fu_func1, fu_src1_1,
                 fu_src2_1, fu_dst1, fu_owner1);
    if (use_table) begin
      check_val("vec_grant_lat2", 32'(grant2), 32'(tg2));
      check_val("vec_grant_lat1", 32'(grant1), 32'(tg1));
    end
    n2 = advance(m2, 2, r, st, w2);
    n1 = advance(m1, 1, r, st, w1);
    @(posedge clk);
    #1;
    m2 = n2;
    m1 = n1;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) begin
      req_func[i*FW +: FW] = FW'(i + 3);
      req_src1[i*TW +: TW] = TW'(i + 8);
      req_src2[i*TW +: TW] = TW'(i + 16);
      req_dst[i*TW +: TW]  = (i == 2) ? TW'(3) : TW'(i + 20);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100};
    vecs[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100};
    vecs[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100};
    vecs[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0100};
    vecs[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100};
    vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000};
    vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0001};
    vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0010};
    vecs[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0100};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 4'b1000};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0001};
    vecs[14] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 4'b1000};
    vecs[15] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0001};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vecs[17] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010};
    vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[19] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[20] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[21] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0100};
    vecs[22] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 4'b1000};
    vecs[23] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000};
    vecs[24] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001};
    vecs[25] = '{1'b0, 4'b0110, 1'b0, 4'b0000, 4'b0010};

    reset     = 1'b1;
    req_valid = '0;
    fu_stall  = 1'b0;
    set_fixed_data();
    repeat (2) @(posedge clk);
    #1;
    m2 = model_reset(2);
    m1 = model_reset(1);

    for (int i = 0; i < 26; i++)
      apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].stall, 1'b1, vecs[i].g2, vecs[i].g1);

    // Stall held across several cycles with a busy FU, then reset while busy.
    apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 4'b1000);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_func[i*FW +: FW] = FW'($urandom);
        req_src1[i*TW +: TW] = TW'($urandom);
        req_src2[i*TW +: TW] = TW'($urandom);
        req_dst[i*TW +: TW]  = TW'($urandom);
      end
      apply_stimulus(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 3) == 0),
                     1'b0, 4'b0000, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
